// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by every execution unit.
package core_config_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/restoring_divider_pkg.sv
// ALU divider types and constants. The state encoding is shared with ALU-level control.
package restoring_divider_pkg;
    import core_config_pkg::*;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    localparam int              DIV_LATENCY   = XLEN + 2;
    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] SIGNED_MIN    = {1'b1, {(XLEN-1){1'b0}}};
endpackage

// File: rtl/restoring_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up afterwards, and a fast path for divide-by-zero and signed overflow.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int XLEN = core_config_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            op_signed,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] Q,
    output logic [XLEN-1:0] R
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem, quo, divisor;
    logic            neg_q, neg_r;

    logic [XLEN-1:0] abs_x, abs_y;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            overflow;

    always_comb begin
        abs_x    = (op_signed && X[XLEN-1]) ? -X : X;
        abs_y    = (op_signed && Y[XLEN-1]) ? -Y : Y;
        overflow = op_signed && (X == MIN_VAL) && (Y == '1);
        // rem < divisor always holds, so the shifted partial remainder fits in XLEN+1 bits.
        shifted  = {rem, quo[XLEN-1]};
        trial    = {1'b0, shifted} - {2'b00, divisor};
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
            Q       <= '0;
            R       <= '0;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // busy is still high during the valid cycle, which blocks start there.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy    <= 1'b1;
                        neg_q   <= op_signed & (X[XLEN-1] ^ Y[XLEN-1]);
                        neg_r   <= op_signed & X[XLEN-1];
                        divisor <= abs_y;
                        if (Y == '0) begin
                            Q     <= '1;
                            R     <= X;
                            state <= DONE;
                        end else if (overflow) begin
                            Q     <= MIN_VAL;
                            R     <= '0;
                            state <= DONE;
                        end else begin
                            count <= '0;
                            rem   <= '0;
                            quo   <= abs_x;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (!trial[XLEN+1]) begin
                            rem <= trial[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= shifted[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        Q     <= neg_q ? -quo : quo;
                        R     <= neg_r ? -rem : rem;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench: directed vectors, control corner sequences and random
// operands against an arithmetic reference model with RISC-V special cases.
module tb_restoring_divider;
    import restoring_divider_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort, op_signed;
    logic [31:0] X, Y;
    logic        busy, valid;
    logic [31:0] Q, R;

    int total = 0;
    int bad   = 0;

    restoring_divider dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op_signed(op_signed),
        .X(X), .Y(Y), .busy(busy), .valid(valid), .Q(Q), .R(R)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 0) begin
            q = '1;
            r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = 0;
        end else if (s) begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for its valid pulse.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output bit busy_ok);
        X = x; Y = y; op_signed = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; busy_ok = 1'b1; q = '0; r = '0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                lat = n; q = Q; r = R;
                break;
            end
        end
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (valid) cnt++;
        end
    endtask

    initial begin
        logic [31:0] q, r, eq, er, x, y;
        logic        s;
        int          lat, cnt, elat, sel;
        bit          bok;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34};
        vecs[3] = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1};
        vecs[4] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          34};
        vecs[8] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          34};

        rst = 1'b1; start = 1'b0; abort = 1'b0; op_signed = 1'b0; X = '0; Y = '0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_q", Q, 32'd0);
        check("reset_r", R, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].s, q, r, lat, bok);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
            tick();
            check($sformatf("vec%0d_valid_once", i), {30'd0, valid, busy}, 32'd0);
        end

        // start re-pulsed mid-operation must be ignored
        X = 32'd100; Y = 32'd7; op_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 10) begin X = 32'd50; Y = 32'd5; start = 1'b1; end
            if (n == 11) start = 1'b0;
            if (valid) begin lat = n; q = Q; r = R; break; end
        end
        check("repulse_lat", lat, 34);
        check("repulse_q", q, 32'd14);
        check("repulse_r", r, 32'd2);
        count_valids(40, cnt);
        check("repulse_no_extra", cnt, 0);

        // abort at cycle 20 kills the operation and leaves Q/R alone
        X = 32'd1000; Y = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (valid) cnt++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_q_held", Q, 32'd14);
        check("abort_r_held", R, 32'd2);
        count_valids(40, lat);
        check("abort_no_valid", cnt + lat, 0);
        run_op(32'd1000, 32'd3, 1'b0, q, r, lat, bok);
        check("post_abort_lat", lat, 34);
        check("post_abort_q", q, 32'd333);
        check("post_abort_r", r, 32'd1);
        tick();

        // rst at cycle 15 clears everything
        X = 32'd500; Y = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 15; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_valid", {31'd0, valid}, 32'd0);
        check("rst_mid_q", Q, 32'd0);
        check("rst_mid_r", R, 32'd0);
        count_valids(40, cnt);
        check("rst_mid_no_valid", cnt, 0);

        // random operands in both modes, with held-result checks between operations
        for (int i = 0; i < 1200; i++) begin
            sel = $urandom_range(0, 9);
            s = 1'(($urandom() & 1));
            x = $urandom();
            y = $urandom();
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) y = 32'($urandom_range(1, 17));
            else if (sel == 3) y = -32'($urandom_range(1, 17));
            ref_div(x, y, s, eq, er);
            elat = (y == 0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : DIV_LATENCY;
            run_op(x, y, s, q, r, lat, bok);
            check("rand_lat", lat, elat);
            check("rand_q", q, eq);
            check("rand_r", r, er);
            for (int g = $urandom_range(0, 3); g >= 0; g--) tick();
            check("rand_q_hold", Q, eq);
            check("rand_r_hold", R, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
